// File: rtl/sm_als_spi_master.sv
// sm_als_spi_master
//   SPI initiator for the PmodALS ambient-light sensor (ADC081S021-style,
//   read-only). One request runs one 16-SCK frame with alsCS low. The 8-bit
//   sample is extracted from the frame and held for the CPU until the next
//   frame completes.
//
// Optional feature macro: SM_ALS_AUTO_EN
//   When defined, a free-running counter also requests a frame every
//   AUTO_PERIOD clks. An expiry that lands outside IDLE is held until the
//   first IDLE clk.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous reset, active high
//   start   in   one-clk request for a sample; ignored while busy
//   busy    out  high from the clk after an accepted start until the end of GAP
//   valid   out  one-clk pulse; data/raw updated in the same clk
//   data    out  last sample, raw[12:5]
//   raw     out  last captured frame; first received bit is in raw[15]
//   alsCS   out  sensor chip select, active low
//   alsSCK  out  SPI clock, idles high
//   alsSDO  in   sensor serial data
module sm_als_spi_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned GAP         = 4,
    parameter int unsigned AUTO_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  data,
    output logic [15:0] raw,
    output logic        alsCS,
    output logic        alsSCK,
    input  logic        alsSDO
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
    localparam int unsigned SETUP_W = $clog2(CS_SETUP + 1);
    localparam int unsigned GAP_W   = $clog2(GAP + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [SETUP_W-1:0] r_setup;
    logic [GAP_W-1:0]   r_gap;
    logic [3:0]         r_bit;
    logic [15:0]        r_shift;
    logic               w_go;

`ifdef SM_ALS_AUTO_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] r_auto_cnt;
    logic              w_auto_req;

    // The counter saturates at its last value, so an expiry outside IDLE
    // stays pending until the FSM returns to IDLE and takes it.
    assign w_auto_req = (r_auto_cnt == AUTO_LAST);
    assign w_go       = start | w_auto_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (w_auto_req) begin
            if (r_state == S_IDLE) begin
                r_auto_cnt <= '0;
            end
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end
`else
    assign w_go = start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_setup <= '0;
            r_gap   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            data    <= '0;
            raw     <= '0;
            alsCS   <= 1'b1;
            alsSCK  <= 1'b1;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_SETUP;
                        r_setup <= '0;
                        alsCS   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_setup == SETUP_LAST) begin
                        r_state <= S_SHIFT;
                        r_div   <= '0;
                        r_bit   <= '0;
                        alsSCK  <= 1'b0;
                    end else begin
                        r_setup <= r_setup + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!alsSCK) begin
                            // Sample in the clk where SCK goes 0->1.
                            alsSCK  <= 1'b1;
                            r_shift <= {r_shift[14:0], alsSDO};
                        end else if (r_bit == 4'd15) begin
                            // High phase of the 16th bit done; SCK stays high.
                            r_state <= S_HOLD;
                            alsCS   <= 1'b1;
                        end else begin
                            alsSCK <= 1'b0;
                            r_bit  <= r_bit + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_HOLD: begin
                    raw     <= r_shift;
                    data    <= r_shift[12:5];
                    valid   <= 1'b1;
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
